control_stage_pipe: RTL and testbench
=====================================

Name: control_stage_pipe

Overview:
- Carries the decoded control bundle from ID through the EX, MEM and WB pipeline stages of the 5-stage RV64 pipeline.
- Detects load-use hazards and generates stall signals for PC and IF/ID.
- Resolves branches in MEM and flushes younger instructions.
- Sits between the main control decoder (opcode -> control bits) and the datapath stage muxes, ALU control and register file write port.

Parameters:
- REG_ADDR_W, 5, register index width.
- ALUOP_W, 2, ALUOp width.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high reset
- id_valid  input  1  ID stage holds a real instruction
- id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead, id_MemWrite, id_Branch  input  1 each  decoder outputs
- id_ALUOp  input  ALUOP_W  decoder ALUOp
- id_rs1, id_rs2, id_rd  input  REG_ADDR_W  ID register fields
- mem_zero  input  1  ALU zero flag registered into EX/MEM
- ex_ALUSrc, ex_MemRead  output  1  EX-stage control
- ex_ALUOp  output  ALUOP_W  to ALU control
- ex_rd  output  REG_ADDR_W
- mem_MemRead, mem_MemWrite  output  1  data memory strobes
- wb_RegWrite, wb_MemtoReg  output  1  writeback control
- wb_rd  output  REG_ADDR_W
- pc_write  output  1  PC load enable
- ifid_write  output  1  IF/ID load enable
- ifid_flush  output  1  IF/ID clear
- pcsrc  output  1  select branch target

Behaviour:
- Three register stages: ID/EX, EX/MEM, MEM/WB.
  - Each holds a valid bit, the control bits still needed downstream, and rd.
  - ID/EX also holds rs1/rs2.
- Reset (async, any time, including mid-stall or mid-flush):
  - All valid bits and all registered control outputs are 0.
  - ex_ALUOp=0; ex_rd=wb_rd=0.
  - Combinational outputs settle to pc_write=1, ifid_write=1, ifid_flush=0, pcsrc=0.
- Every registered output is forced to 0 whenever its stage valid bit is 0. An x on id_MemtoReg (SD/BEQ) must never reach wb_MemtoReg when wb_RegWrite=0; drive 0 instead.
- Latency:
  - ID bundle appears on ex_* 1 cycle after capture.
  - mem_* appear after 2 cycles; wb_* after 3 cycles.
- Load-use stall (combinational): asserted when ex_valid & ex_MemRead & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2) & id_valid.
  - pc_write=0 and ifid_write=0.
  - ID/EX loads a bubble (valid=0).
  - EX/MEM and MEM/WB advance normally.
  - Stall lasts exactly 1 cycle per load-use pair.
- Branch resolution: pcsrc = mem_valid & mem_Branch & mem_zero (combinational, MEM stage).
  - When pcsrc=1: ifid_flush=1, ID/EX loads a bubble, EX/MEM loads a bubble.
  - MEM/WB captures the branch normally (RegWrite=0).
- Simultaneous stall and pcsrc: flush wins.
  - pc_write=1, ifid_write=1, ifid_flush=1.
  - The stalled pair is discarded.
- Register x0: rd=0 never triggers a stall.
  - wb_RegWrite passes through unchanged; the register file ignores x0.
- No internal state machine beyond the pipeline registers. The hazard, stall and flush logic is purely combinational on the current stage state.

Optional Feature:
- Macro: CONTROL_FORWARD_EN.
- With it defined, the block adds:
  - Ports forward_a and forward_b (output, 2 bits each).
  - Registered EX-stage outputs ex_rs1 and ex_rs2.
- Forward encoding per operand:
  - 2'b10 when mem_valid & mem_RegWrite & mem_rd!=0 & mem_rd==ex_rs.
  - Else 2'b01 when wb_valid & wb_RegWrite & wb_rd!=0 & wb_rd==ex_rs.
  - Else 2'b00.
  - MEM has priority over WB.
- Reset value of forward_a and forward_b is 2'b00.
- Without the macro: these ports and registers do not exist. The datapath relies on the stall path only; stall conditions are unchanged.

Test Plan:
- Reset then R-format bundle (ALUSrc=0, RegWrite=1, ALUOp=10, rd=5) with id_valid=1 -> cycle+1 ex_ALUOp=10; cycle+3 wb_RegWrite=1, wb_rd=5, wb_MemtoReg=0.
- LD rd=6 in EX while ID has rs1=6 -> pc_write=0, ifid_write=0 for 1 cycle; ex_* all 0 the next cycle; the LD reaches wb with MemtoReg=1.
- LD rd=0 in EX while ID has rs1=0 -> no stall; pc_write=1.
- BEQ (Branch=1, ALUOp=01) in MEM with mem_zero=1 -> pcsrc=1, ifid_flush=1; the next cycle's ex_* and mem_* outputs are 0. With mem_zero=0 -> pcsrc=0 and no flush.
- Load-use stall and taken branch in the same cycle -> pc_write=1, ifid_flush=1, no bubble-hold. Assert reset mid-stall -> all outputs return to reset values immediately.
- With CONTROL_FORWARD_EN: back-to-back R-format writing rd=7 then reading rs1=7 -> forward_a=10. With one unrelated instruction in between -> forward_a=01. Both MEM and WB matching -> forward_a=10.

Source files
------------

// File: rtl/control_stage_pipe_if.sv
// rtl/control_stage_pipe_if.sv - decoder/datapath bundle for control_stage_pipe; forwarding signals exist only with CONTROL_FORWARD_EN
interface control_stage_pipe_if #(
    parameter int REG_ADDR_W = 5,
    parameter int ALUOP_W    = 2
);
    logic                  id_valid;
    logic                  id_ALUSrc;
    logic                  id_MemtoReg;
    logic                  id_RegWrite;
    logic                  id_MemRead;
    logic                  id_MemWrite;
    logic                  id_Branch;
    logic [ALUOP_W-1:0]    id_ALUOp;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  mem_zero;

    logic                  ex_ALUSrc;
    logic                  ex_MemRead;
    logic [ALUOP_W-1:0]    ex_ALUOp;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  mem_MemRead;
    logic                  mem_MemWrite;
    logic                  wb_RegWrite;
    logic                  wb_MemtoReg;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic                  pc_write;
    logic                  ifid_write;
    logic                  ifid_flush;
    logic                  pcsrc;
`ifdef CONTROL_FORWARD_EN
    logic [REG_ADDR_W-1:0] ex_rs1;
    logic [REG_ADDR_W-1:0] ex_rs2;
    logic [1:0]            forward_a;
    logic [1:0]            forward_b;
`endif

    modport master (
`ifdef CONTROL_FORWARD_EN
        input  ex_rs1, ex_rs2, forward_a, forward_b,
`endif
        output id_valid, id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead,
               id_MemWrite, id_Branch, id_ALUOp, id_rs1, id_rs2, id_rd, mem_zero,
        input  ex_ALUSrc, ex_MemRead, ex_ALUOp, ex_rd, mem_MemRead, mem_MemWrite,
               wb_RegWrite, wb_MemtoReg, wb_rd, pc_write, ifid_write, ifid_flush, pcsrc
    );

    modport slave (
`ifdef CONTROL_FORWARD_EN
        output ex_rs1, ex_rs2, forward_a, forward_b,
`endif
        input  id_valid, id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead,
               id_MemWrite, id_Branch, id_ALUOp, id_rs1, id_rs2, id_rd, mem_zero,
        output ex_ALUSrc, ex_MemRead, ex_ALUOp, ex_rd, mem_MemRead, mem_MemWrite,
               wb_RegWrite, wb_MemtoReg, wb_rd, pc_write, ifid_write, ifid_flush, pcsrc
    );
endinterface

// File: rtl/control_stage_pipe.sv
// rtl/control_stage_pipe.sv - ID/EX/MEM/WB control pipeline with load-use stall and MEM-stage branch flush
// Optional operand forwarding select under CONTROL_FORWARD_EN.
module control_stage_pipe #(
    parameter int REG_ADDR_W = 5,
    parameter int ALUOP_W    = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    control_stage_pipe_if.slave     bus
);
    typedef struct packed {
        logic                  valid;
        logic                  alusrc;
        logic                  memtoreg;
        logic                  regwrite;
        logic                  memread;
        logic                  memwrite;
        logic                  branch;
        logic [ALUOP_W-1:0]    aluop;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
    } idex_t;

    typedef struct packed {
        logic                  valid;
        logic                  memtoreg;
        logic                  regwrite;
        logic                  memread;
        logic                  memwrite;
        logic                  branch;
        logic [REG_ADDR_W-1:0] rd;
    } exmem_t;

    typedef struct packed {
        logic                  valid;
        logic                  memtoreg;
        logic                  regwrite;
        logic [REG_ADDR_W-1:0] rd;
    } memwb_t;

    idex_t  idex_q,  idex_d;
    exmem_t exmem_q, exmem_d;
    memwb_t memwb_q, memwb_d;

    logic stall;
    logic flush;

    always_comb begin
        stall = idex_q.valid & idex_q.memread & (idex_q.rd != '0) & bus.id_valid &
                ((idex_q.rd == bus.id_rs1) | (idex_q.rd == bus.id_rs2));
        flush = exmem_q.valid & exmem_q.branch & bus.mem_zero;

        // Gating MemtoReg with RegWrite keeps an undefined decoder bit on stores/branches out of WB.
        idex_d = '0;
        if (bus.id_valid && !stall && !flush) begin
            idex_d.valid    = 1'b1;
            idex_d.alusrc   = bus.id_ALUSrc;
            idex_d.memtoreg = bus.id_MemtoReg & bus.id_RegWrite;
            idex_d.regwrite = bus.id_RegWrite;
            idex_d.memread  = bus.id_MemRead;
            idex_d.memwrite = bus.id_MemWrite;
            idex_d.branch   = bus.id_Branch;
            idex_d.aluop    = bus.id_ALUOp;
            idex_d.rs1      = bus.id_rs1;
            idex_d.rs2      = bus.id_rs2;
            idex_d.rd       = bus.id_rd;
        end

        exmem_d = '0;
        if (idex_q.valid && !flush) begin
            exmem_d.valid    = 1'b1;
            exmem_d.memtoreg = idex_q.memtoreg;
            exmem_d.regwrite = idex_q.regwrite;
            exmem_d.memread  = idex_q.memread;
            exmem_d.memwrite = idex_q.memwrite;
            exmem_d.branch   = idex_q.branch;
            exmem_d.rd       = idex_q.rd;
        end

        memwb_d = '0;
        if (exmem_q.valid) begin
            memwb_d.valid    = 1'b1;
            memwb_d.memtoreg = exmem_q.memtoreg;
            memwb_d.regwrite = exmem_q.regwrite;
            memwb_d.rd       = exmem_q.rd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
        end else begin
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end
    end

    assign bus.ex_ALUSrc    = idex_q.valid & idex_q.alusrc;
    assign bus.ex_MemRead   = idex_q.valid & idex_q.memread;
    assign bus.ex_ALUOp     = idex_q.valid ? idex_q.aluop : '0;
    assign bus.ex_rd        = idex_q.valid ? idex_q.rd : '0;
    assign bus.mem_MemRead  = exmem_q.valid & exmem_q.memread;
    assign bus.mem_MemWrite = exmem_q.valid & exmem_q.memwrite;
    assign bus.wb_RegWrite  = memwb_q.valid & memwb_q.regwrite;
    assign bus.wb_MemtoReg  = memwb_q.valid & memwb_q.regwrite & memwb_q.memtoreg;
    assign bus.wb_rd        = memwb_q.valid ? memwb_q.rd : '0;

    // A taken branch overrides the stall so the redirected fetch proceeds.
    assign bus.pc_write     = ~stall | flush;
    assign bus.ifid_write   = ~stall | flush;
    assign bus.ifid_flush   = flush;
    assign bus.pcsrc        = flush;

`ifdef CONTROL_FORWARD_EN
    function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs);
        logic [1:0] sel;
        sel = 2'b00;
        if (memwb_q.valid && memwb_q.regwrite && (memwb_q.rd != '0) && (memwb_q.rd == rs))
            sel = 2'b01;
        if (exmem_q.valid && exmem_q.regwrite && (exmem_q.rd != '0) && (exmem_q.rd == rs))
            sel = 2'b10;
        return sel;
    endfunction

    assign bus.ex_rs1    = idex_q.valid ? idex_q.rs1 : '0;
    assign bus.ex_rs2    = idex_q.valid ? idex_q.rs2 : '0;
    assign bus.forward_a = idex_q.valid ? fwd_sel(idex_q.rs1) : 2'b00;
    assign bus.forward_b = idex_q.valid ? fwd_sel(idex_q.rs2) : 2'b00;
`endif
endmodule

// File: tb/tb_control_stage_pipe.sv
// tb/tb_control_stage_pipe.sv - directed self-checking bench for control_stage_pipe (CONTROL_FORWARD_EN steps included when defined)
module tb_control_stage_pipe;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    control_stage_pipe_if #(.REG_ADDR_W(5), .ALUOP_W(2)) bus ();

    control_stage_pipe #(.REG_ADDR_W(5), .ALUOP_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_id();
        bus.id_valid    = 1'b0;
        bus.id_ALUSrc   = 1'b0;
        bus.id_MemtoReg = 1'b0;
        bus.id_RegWrite = 1'b0;
        bus.id_MemRead  = 1'b0;
        bus.id_MemWrite = 1'b0;
        bus.id_Branch   = 1'b0;
        bus.id_ALUOp    = 2'b00;
        bus.id_rs1      = 5'd0;
        bus.id_rs2      = 5'd0;
        bus.id_rd       = 5'd0;
    endtask

    task automatic set_r(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        clear_id();
        bus.id_valid    = 1'b1;
        bus.id_RegWrite = 1'b1;
        bus.id_ALUOp    = 2'b10;
        bus.id_rd       = rd;
        bus.id_rs1      = rs1;
        bus.id_rs2      = rs2;
    endtask

    task automatic set_ld(input logic [4:0] rd, input logic [4:0] rs1);
        clear_id();
        bus.id_valid    = 1'b1;
        bus.id_ALUSrc   = 1'b1;
        bus.id_MemtoReg = 1'b1;
        bus.id_RegWrite = 1'b1;
        bus.id_MemRead  = 1'b1;
        bus.id_rd       = rd;
        bus.id_rs1      = rs1;
    endtask

    task automatic set_beq(input logic [4:0] rs1, input logic [4:0] rs2);
        clear_id();
        bus.id_valid    = 1'b1;
        bus.id_Branch   = 1'b1;
        bus.id_ALUOp    = 2'b01;
        bus.id_MemtoReg = 1'bx;
        bus.id_rs1      = rs1;
        bus.id_rs2      = rs2;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clear_id();
        bus.mem_zero = 1'b0;
        reset = 1'b1;
        #12;
        chk("rst_ex_ALUOp", {6'd0, bus.ex_ALUOp}, 8'd0);
        chk("rst_wb_rd", {3'd0, bus.wb_rd}, 8'd0);
        chk("rst_wb_RegWrite", {7'd0, bus.wb_RegWrite}, 8'd0);
        chk("rst_pc_write", {7'd0, bus.pc_write}, 8'd1);
        chk("rst_ifid_flush", {7'd0, bus.ifid_flush}, 8'd0);
        reset = 1'b0;

        // R-format rd=5 through the pipe
        set_r(5'd5, 5'd1, 5'd2);
        tick();
        clear_id();
        chk("r_ex_ALUOp", {6'd0, bus.ex_ALUOp}, 8'h2);
        chk("r_ex_rd", {3'd0, bus.ex_rd}, 8'd5);
        tick();
        tick();
        chk("r_wb_RegWrite", {7'd0, bus.wb_RegWrite}, 8'd1);
        chk("r_wb_rd", {3'd0, bus.wb_rd}, 8'd5);
        chk("r_wb_MemtoReg", {7'd0, bus.wb_MemtoReg}, 8'd0);

        // Load-use: LD x6 in EX, consumer reads x6
        set_ld(5'd6, 5'd1);
        tick();
        set_r(5'd8, 5'd6, 5'd2);
        #1;
        chk("lu_pc_write", {7'd0, bus.pc_write}, 8'd0);
        chk("lu_ifid_write", {7'd0, bus.ifid_write}, 8'd0);
        tick();
        chk("lu_bub_ALUOp", {6'd0, bus.ex_ALUOp}, 8'd0);
        chk("lu_bub_MemRead", {7'd0, bus.ex_MemRead}, 8'd0);
        chk("lu_bub_rd", {3'd0, bus.ex_rd}, 8'd0);
        chk("lu_bub_ALUSrc", {7'd0, bus.ex_ALUSrc}, 8'd0);
        chk("lu_release_pc_write", {7'd0, bus.pc_write}, 8'd1);
        chk("lu_mem_MemRead", {7'd0, bus.mem_MemRead}, 8'd1);
        tick();
        clear_id();
        chk("lu_wb_MemtoReg", {7'd0, bus.wb_MemtoReg}, 8'd1);
        chk("lu_wb_rd", {3'd0, bus.wb_rd}, 8'd6);
        chk("lu_ex_rd_after", {3'd0, bus.ex_rd}, 8'd8);

        // LD x0 never stalls
        set_ld(5'd0, 5'd3);
        tick();
        set_r(5'd9, 5'd0, 5'd4);
        #1;
        chk("x0_ex_MemRead", {7'd0, bus.ex_MemRead}, 8'd1);
        chk("x0_pc_write", {7'd0, bus.pc_write}, 8'd1);
        chk("x0_ifid_write", {7'd0, bus.ifid_write}, 8'd1);
        tick();
        clear_id();

        // Taken BEQ in MEM flushes EX and ID
        set_beq(5'd1, 5'd2);
        tick();
        set_r(5'd10, 5'd11, 5'd12);
        tick();
        set_r(5'd13, 5'd1, 5'd2);
        bus.mem_zero = 1'b1;
        #1;
        chk("br_pcsrc", {7'd0, bus.pcsrc}, 8'd1);
        chk("br_ifid_flush", {7'd0, bus.ifid_flush}, 8'd1);
        chk("br_ex_rd_pre", {3'd0, bus.ex_rd}, 8'd10);
        tick();
        clear_id();
        chk("br_ex_rd", {3'd0, bus.ex_rd}, 8'd0);
        chk("br_ex_ALUOp", {6'd0, bus.ex_ALUOp}, 8'd0);
        chk("br_mem_MemWrite", {7'd0, bus.mem_MemWrite}, 8'd0);
        chk("br_mem_MemRead", {7'd0, bus.mem_MemRead}, 8'd0);
        chk("br_wb_RegWrite", {7'd0, bus.wb_RegWrite}, 8'd0);
        chk("br_wb_MemtoReg", {7'd0, bus.wb_MemtoReg}, 8'd0);
        chk("br_pcsrc_after", {7'd0, bus.pcsrc}, 8'd0);
        bus.mem_zero = 1'b0;

        // Not-taken BEQ
        set_beq(5'd3, 5'd4);
        tick();
        clear_id();
        tick();
        #1;
        chk("bnt_pcsrc", {7'd0, bus.pcsrc}, 8'd0);
        chk("bnt_ifid_flush", {7'd0, bus.ifid_flush}, 8'd0);
        tick();

        // Stall and taken branch in the same cycle
        set_beq(5'd1, 5'd2);
        tick();
        set_ld(5'd14, 5'd1);
        tick();
        set_r(5'd15, 5'd14, 5'd2);
        bus.mem_zero = 1'b1;
        #1;
        chk("sb_pc_write", {7'd0, bus.pc_write}, 8'd1);
        chk("sb_ifid_write", {7'd0, bus.ifid_write}, 8'd1);
        chk("sb_ifid_flush", {7'd0, bus.ifid_flush}, 8'd1);
        tick();
        clear_id();
        bus.mem_zero = 1'b0;
        chk("sb_ex_rd", {3'd0, bus.ex_rd}, 8'd0);
        chk("sb_mem_MemRead", {7'd0, bus.mem_MemRead}, 8'd0);
        chk("sb_wb_RegWrite", {7'd0, bus.wb_RegWrite}, 8'd0);
        tick();

`ifdef CONTROL_FORWARD_EN
        set_r(5'd7, 5'd1, 5'd2);
        tick();
        set_r(5'd20, 5'd7, 5'd3);
        tick();
        chk("fw_mem_a", {6'd0, bus.forward_a}, 8'h2);
        chk("fw_mem_b", {6'd0, bus.forward_b}, 8'h0);
        chk("fw_ex_rs1", {3'd0, bus.ex_rs1}, 8'd7);
        set_r(5'd7, 5'd1, 5'd2);
        tick();
        set_r(5'd21, 5'd1, 5'd2);
        tick();
        set_r(5'd22, 5'd7, 5'd7);
        tick();
        chk("fw_wb_a", {6'd0, bus.forward_a}, 8'h1);
        chk("fw_wb_b", {6'd0, bus.forward_b}, 8'h1);
        set_r(5'd7, 5'd1, 5'd2);
        tick();
        set_r(5'd7, 5'd3, 5'd4);
        tick();
        set_r(5'd23, 5'd7, 5'd0);
        tick();
        clear_id();
        chk("fw_both_a", {6'd0, bus.forward_a}, 8'h2);
        chk("fw_x0_b", {6'd0, bus.forward_b}, 8'h0);
        tick();
`endif

        // Reset asserted in the middle of a stall
        set_ld(5'd16, 5'd1);
        tick();
        set_r(5'd17, 5'd16, 5'd0);
        #1;
        chk("rs_stall_pc_write", {7'd0, bus.pc_write}, 8'd0);
        chk("rs_stall_ex_MemRead", {7'd0, bus.ex_MemRead}, 8'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("rs_pc_write", {7'd0, bus.pc_write}, 8'd1);
        chk("rs_ifid_write", {7'd0, bus.ifid_write}, 8'd1);
        chk("rs_ex_MemRead", {7'd0, bus.ex_MemRead}, 8'd0);
        chk("rs_ex_rd", {3'd0, bus.ex_rd}, 8'd0);
        chk("rs_wb_rd", {3'd0, bus.wb_rd}, 8'd0);
        chk("rs_pcsrc", {7'd0, bus.pcsrc}, 8'd0);
        clear_id();
        tick();
        reset = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
